// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 64-bit ripple ALU: decodes RV64 ALU/branch ops into ALU control codes,
// sequences the three-pass XOR, and returns result/flags/branch decision over valid/ready.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op_class,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic [63:0] op_a,
    input  logic [63:0] op_b,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [63:0] alu_r,
    input  logic        alu_zero,
    input  logic        alu_ovf,
    input  logic        alu_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic        res_zero,
    output logic        res_ovf,
    output logic        res_cout,
    output logic        br_taken,
    output logic        illegal
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_ANDN = 4'b0100;

    typedef enum logic [2:0] {IDLE, EXEC1, EXEC2, EXEC3, RESP} state_t;
    // ARITH keeps the ALU ovf/cout flags; LOGIC/SLTU/XOR report them as zero
    typedef enum logic [2:0] {K_ARITH, K_LOGIC, K_SLTU, K_XOR, K_BR} kind_t;

    state_t      state;
    kind_t       kind_q;
    logic [2:0]  f3_q;
    logic [63:0] or_p1;

    logic [3:0]  dec_op;
    kind_t       dec_kind;
    logic        dec_ill;

    always_comb begin
        dec_op   = OP_ADD;
        dec_kind = K_ARITH;
        dec_ill  = 1'b0;
        case (op_class)
            2'b00: dec_op = OP_ADD;
            2'b01: begin
                case (funct3)
                    3'b000, 3'b001, 3'b110, 3'b111: begin
                        dec_op   = OP_SUB;
                        dec_kind = K_BR;
                    end
                    3'b100, 3'b101: begin
                        dec_op   = OP_SLT;
                        dec_kind = K_BR;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            default: begin
                case (funct3)
                    3'b000: dec_op = (op_class == 2'b10 && funct7_5) ? OP_SUB : OP_ADD;
                    3'b111: begin
                        dec_op   = OP_AND;
                        dec_kind = K_LOGIC;
                    end
                    3'b110: begin
                        dec_op   = OP_OR;
                        dec_kind = K_LOGIC;
                    end
                    3'b010: dec_op = OP_SLT;
                    3'b011: begin
                        dec_op   = OP_SUB;
                        dec_kind = K_SLTU;
                    end
                    3'b100: begin
                        dec_op   = OP_OR;
                        dec_kind = K_XOR;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
        endcase
    end

    logic [63:0] fin_r;
    logic        keep_flags;
    logic        taken;

    always_comb begin
        fin_r      = (kind_q == K_SLTU) ? {63'b0, ~alu_cout} : alu_r;
        keep_flags = (kind_q == K_ARITH) || (kind_q == K_BR);
        case (f3_q)
            3'b000:  taken = alu_zero;
            3'b001:  taken = ~alu_zero;
            3'b100:  taken = alu_r[0];
            3'b101:  taken = ~alu_r[0];
            3'b110:  taken = ~alu_cout;
            3'b111:  taken = alu_cout;
            default: taken = 1'b0;
        endcase
    end

    // first XOR pass result (A | B), consumed as the ANDN left operand
    always_ff @(posedge clk) begin
        if (state == EXEC1)
            or_p1 <= alu_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            kind_q    <= K_ARITH;
            f3_q      <= 3'b000;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            alu_a     <= 64'b0;
            alu_b     <= 64'b0;
            alu_op    <= 4'b0000;
            result    <= 64'b0;
            res_zero  <= 1'b0;
            res_ovf   <= 1'b0;
            res_cout  <= 1'b0;
            br_taken  <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        kind_q   <= dec_kind;
                        f3_q     <= funct3;
                        if (dec_ill) begin
                            state     <= RESP;
                            out_valid <= 1'b1;
                            result    <= 64'b0;
                            res_zero  <= 1'b0;
                            res_ovf   <= 1'b0;
                            res_cout  <= 1'b0;
                            br_taken  <= 1'b0;
                            illegal   <= 1'b1;
                        end else begin
                            alu_a   <= op_a;
                            alu_b   <= op_b;
                            alu_op  <= dec_op;
                            illegal <= 1'b0;
                            state   <= EXEC1;
                        end
                    end
                end
                EXEC1: begin
                    if (kind_q == K_XOR) begin
                        alu_op <= OP_AND;
                        state  <= EXEC2;
                    end else begin
                        result    <= fin_r;
                        res_zero  <= (fin_r == 64'b0);
                        res_ovf   <= keep_flags & alu_ovf;
                        res_cout  <= keep_flags & alu_cout;
                        br_taken  <= (kind_q == K_BR) & taken;
                        out_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                EXEC2: begin
                    // ANDN(T1, A&B) clears the bits where both operands were set
                    alu_a  <= or_p1;
                    alu_b  <= alu_r;
                    alu_op <= OP_ANDN;
                    state  <= EXEC3;
                end
                EXEC3: begin
                    result    <= alu_r;
                    res_zero  <= (alu_r == 64'b0);
                    res_ovf   <= 1'b0;
                    res_cout  <= 1'b0;
                    br_taken  <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
